// File: rtl/mem_stall_ctrl.sv
// Memory-stage stall controller: data request issue, miss freeze, fetch bubbles.
// Optional watchdog on long misses: define MEM_STALL_WATCHDOG_EN.
module mem_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DMemEn_tomem,
  input  logic             DMemWrite_tomem,
  input  logic             Halt_tomem,
  input  logic             DMemDone,
  input  logic             IMemStall,
  output logic             DMemRd,
  output logic             DMemWr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_bubble,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err
);

  typedef enum logic {
    IDLE,
    WAIT
  } stateT;

  stateT state;
  stateT stateNext;
  logic req;
  logic dstall;
  logic opWrite;
  logic rdReq;
  logic wrReq;

  assign req = DMemEn_tomem & ~Halt_tomem & ~rst;

  // Next state, request polarity and data-stall decision.
  always_comb begin
    stateNext = state;
    dstall = 1'b0;
    rdReq = 1'b0;
    wrReq = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          rdReq = ~DMemWrite_tomem;
          wrReq = DMemWrite_tomem;
          if (!DMemDone) begin
            dstall = 1'b1;
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        rdReq = ~opWrite;
        wrReq = opWrite;
        if (DMemDone) begin
          stateNext = IDLE;
        end else begin
          dstall = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (rst) begin
      stateNext = IDLE;
      dstall = 1'b0;
      rdReq = 1'b0;
      wrReq = 1'b0;
    end
  end

  assign DMemRd = rdReq;
  assign DMemWr = wrReq;

  // Pipeline enables and bubbles; data stall outranks fetch stall.
  always_comb begin
    pc_en = 1'b1;
    ifid_en = 1'b1;
    idex_en = 1'b1;
    exmem_en = 1'b1;
    memwb_en = 1'b1;
    ifid_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (dstall) begin
      pc_en = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exmem_en = 1'b0;
      memwb_bubble = 1'b1;
    end else if (!rst) begin
      if (IMemStall) begin
        pc_en = 1'b0;
        ifid_bubble = 1'b1;
      end
      if (Halt_tomem) begin
        pc_en = 1'b0;
      end
    end
  end

  // State register; the access type is captured so a miss keeps its polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opWrite <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && req) begin
        opWrite <= DMemWrite_tomem;
      end
    end
  end

  // Saturating count of data-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (dstall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

`ifdef MEM_STALL_WATCHDOG_EN
  localparam int WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wdCnt;
  logic errQ;

  // Count WAIT cycles of the current miss; flag a sticky error on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdCnt <= '0;
      errQ <= 1'b0;
    end else begin
      if (state == IDLE && stateNext == WAIT) begin
        wdCnt <= '0;
      end else if (state == WAIT && wdCnt != WdW'(TIMEOUT_CYCLES)) begin
        wdCnt <= wdCnt + 1'b1;
      end
      if (state == WAIT && wdCnt == WdW'(TIMEOUT_CYCLES - 1)) begin
        errQ <= 1'b1;
      end
    end
  end

  assign err = errQ;
`else
  assign err = 1'b0;
`endif

endmodule
